// File: rtl/sobel_3x3_if.sv
// Pixel stream bundle between the line buffer taps, the Sobel stage and its consumer.
// master drives samples and the clken strobe; slave returns the edge pixel stream.
interface sobel_3x3_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  clken;
  logic [DATA_WIDTH-1:0] row_top;
  logic [DATA_WIDTH-1:0] row_mid;
  logic [DATA_WIDTH-1:0] row_bot;
  logic [DATA_WIDTH-1:0] dout;
  logic                  dout_valid;
  logic                  dout_last;

  modport master (
    output clken, row_top, row_mid, row_bot,
    input  dout, dout_valid, dout_last
  );

  modport slave (
    input  clken, row_top, row_mid, row_bot,
    output dout, dout_valid, dout_last
  );
endinterface

// File: rtl/sobel_3x3.sv
// 3x3 Sobel |Gx|+|Gy| edge stage, 4-stage pipeline, one output pixel per input pixel.
// Optional SOBEL_BINARY_EN: binarise the saturated magnitude against THRESHOLD.
module sobel_3x3 #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 128,
  parameter int IMG_HEIGHT = 128,
  parameter int THRESHOLD  = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  sobel_3x3_if.slave  pix
);

   localparam int STAGES = 4;
   localparam int PW     = DATA_WIDTH + 2;
   localparam int MW     = DATA_WIDTH + 3;
   localparam int CW     = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
   localparam int RW     = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
   localparam logic [MW-1:0] PIX_MAX  = MW'((1 << DATA_WIDTH) - 1);

   typedef struct packed {
      logic [PW-1:0] gx_pos;
      logic [PW-1:0] gx_neg;
      logic [PW-1:0] gy_pos;
      logic [PW-1:0] gy_neg;
      logic          inner;
      logic          last;
   } s2_t;

   typedef struct packed {
      logic [MW-1:0] mag;
      logic          inner;
      logic          last;
   } s3_t;

   // win[r][c]: r=0 top .. 2 bottom, c=0 oldest .. 2 newest
   logic [2:0][2:0][DATA_WIDTH-1:0] win;
   logic [CW-1:0]         col;
   logic [RW-1:0]         row;
   logic                  tag_inner, tag_last;
   logic [STAGES:1]       vld_pipe;
   s2_t                   s2, s2_d;
   s3_t                   s3, s3_d;
   logic [DATA_WIDTH-1:0] sat, edge_val;
   logic [DATA_WIDTH-1:0] dout_q;
   logic                  last_q;

   function automatic logic [PW-1:0] tri_sum(input logic [DATA_WIDTH-1:0] a,
                                             input logic [DATA_WIDTH-1:0] b,
                                             input logic [DATA_WIDTH-1:0] c);
      return PW'(a) + (PW'(b) << 1) + PW'(c);
   endfunction

   function automatic logic [PW-1:0] abs_diff(input logic [PW-1:0] a, input logic [PW-1:0] b);
      return (a >= b) ? (a - b) : (b - a);
   endfunction

   // Stage 1: window shift and position tag, advanced only on clken
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win       <= '0;
         col       <= '0;
         row       <= '0;
         tag_inner <= 1'b0;
         tag_last  <= 1'b0;
      end else if (pix.clken) begin
         for (int r = 0; r < 3; r++) begin
            win[r][0] <= win[r][1];
            win[r][1] <= win[r][2];
         end
         win[0][2] <= pix.row_top;
         win[1][2] <= pix.row_mid;
         win[2][2] <= pix.row_bot;
         tag_inner <= (row >= RW'(2)) && (col >= CW'(2));
         tag_last  <= (row == ROW_LAST) && (col == COL_LAST);
         if (col == COL_LAST) begin
            col <= '0;
            row <= (row == ROW_LAST) ? '0 : row + RW'(1);
         end else begin
            col <= col + CW'(1);
         end
      end
   end

   always_comb begin
      s2_d        = '0;
      s2_d.gx_pos = tri_sum(win[0][2], win[1][2], win[2][2]);
      s2_d.gx_neg = tri_sum(win[0][0], win[1][0], win[2][0]);
      s2_d.gy_pos = tri_sum(win[2][0], win[2][1], win[2][2]);
      s2_d.gy_neg = tri_sum(win[0][0], win[0][1], win[0][2]);
      s2_d.inner  = tag_inner;
      s2_d.last   = tag_last;
   end

   always_comb begin
      s3_d       = '0;
      s3_d.mag   = MW'(abs_diff(s2.gx_pos, s2.gx_neg)) + MW'(abs_diff(s2.gy_pos, s2.gy_neg));
      s3_d.inner = s2.inner;
      s3_d.last  = s2.last;
   end

   always_comb begin
      sat = (s3.mag > PIX_MAX) ? '1 : s3.mag[DATA_WIDTH-1:0];
`ifdef SOBEL_BINARY_EN
      edge_val = (MW'(sat) >= MW'(THRESHOLD)) ? '1 : '0;
`else
      edge_val = sat;
`endif
      if (!s3.inner) edge_val = '0;
   end

   // Stages 2-4 run every clk; the valid bit marks which slots carry real pixels
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe <= '0;
         s2       <= '0;
         s3       <= '0;
         dout_q   <= '0;
         last_q   <= 1'b0;
      end else begin
         vld_pipe <= {vld_pipe[STAGES-1:1], pix.clken};
         s2       <= s2_d;
         s3       <= s3_d;
         if (vld_pipe[STAGES-1]) begin
            dout_q <= edge_val;
            last_q <= s3.last;
         end
      end
   end

   assign pix.dout       = dout_q;
   assign pix.dout_valid = vld_pipe[STAGES];
   assign pix.dout_last  = last_q;

endmodule

// File: tb/tb_sobel_3x3.sv
// Randomised self-checking bench for sobel_3x3 against a direct image-domain Sobel model.
// Small image size keeps every scenario a full frame while staying short.
module tb_sobel_3x3;
  localparam int DW  = 8;
  localparam int W   = 32;
  localparam int H   = 20;
  localparam int THR = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  sobel_3x3_if #(.DATA_WIDTH(DW)) bus ();

  sobel_3x3 #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H), .THRESHOLD(THR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pix   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int img[H][W];

  typedef struct {
    int val;
    int last;
    int cyc;
  } exp_t;
  exp_t expq[$];

  int nvalid = 0;
  int prev_d = 0;
  int prev_l = 0;

  // Edge value for sample (r,c): Sobel at image centre (r-1,c-1), zero on the 2-pixel border
  function automatic int ref_pix(input int r, input int c);
    int gx, gy, wgt, mag;
    if (r < 2 || c < 2) return 0;
    gx = 0;
    gy = 0;
    for (int i = 0; i < 3; i++) begin
      wgt = (i == 1) ? 2 : 1;
      gx += wgt * (img[r-2+i][c] - img[r-2+i][c-2]);
      gy += wgt * (img[r][c-2+i] - img[r-2][c-2+i]);
    end
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    if (mag > 255) mag = 255;
`ifdef SOBEL_BINARY_EN
    mag = (mag >= THR) ? 255 : 0;
`endif
    return mag;
  endfunction

  task automatic fill(input int kind);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        case (kind)
          0:       img[r][c] = 100;
          1:       img[r][c] = (c >= W/2) ? 200 : 0;
          2:       img[r][c] = c;
          default: img[r][c] = $urandom_range(255);
        endcase
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_d = 0;
      prev_l = 0;
    end else begin
      if (bus.dout_valid) begin
        nvalid++;
        if (expq.size() == 0) chk("spurious_valid", 1, 0);
        else begin
          exp_t e;
          e = expq.pop_front();
          chk("dout", int'(bus.dout), e.val);
          chk("dout_last", int'(bus.dout_last), e.last);
          chk("latency", cyc, e.cyc);
        end
      end else begin
        chk("hold_dout", int'(bus.dout), prev_d);
        chk("hold_last", int'(bus.dout_last), prev_l);
      end
      prev_d = int'(bus.dout);
      prev_l = int'(bus.dout_last);
    end
  end

  // Rows above the frame start are garbage: the border rule must hide them
  task automatic drive_frame(input int gap_pct, input int stop_row);
    for (int r = 0; r < H; r++) begin
      if (r == stop_row) break;
      for (int c = 0; c < W; c++) begin
        while (int'($urandom_range(99)) < gap_pct) begin
          bus.clken   = 1'b0;
          bus.row_top = DW'($urandom_range(255));
          bus.row_mid = DW'($urandom_range(255));
          bus.row_bot = DW'($urandom_range(255));
          @(negedge clk);
        end
        bus.clken   = 1'b1;
        bus.row_bot = DW'(img[r][c]);
        bus.row_mid = (r >= 1) ? DW'(img[r-1][c]) : DW'($urandom_range(255));
        bus.row_top = (r >= 2) ? DW'(img[r-2][c]) : DW'($urandom_range(255));
        expq.push_back('{ref_pix(r, c), (r == H-1 && c == W-1) ? 1 : 0, cyc + 4});
        @(negedge clk);
      end
    end
    bus.clken = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && expq.size() > 0; i++) @(negedge clk);
    chk("drain", expq.size(), 0);
  endtask

  task automatic run_frame(input int kind, input int gap_pct);
    fill(kind);
    nvalid = 0;
    drive_frame(gap_pct, H);
    drain();
    chk("valid_count", nvalid, W*H);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_dout", int'(bus.dout), 0);
    chk("rst_valid", int'(bus.dout_valid), 0);
    chk("rst_last", int'(bus.dout_last), 0);
  endtask

  initial begin
    bus.clken   = 1'b0;
    bus.row_top = '0;
    bus.row_mid = '0;
    bus.row_bot = '0;
    rst_n       = 1'b0;
    repeat (4) begin
      @(negedge clk);
      bus.clken = ~bus.clken;
      chk_reset_outputs();
    end
    bus.clken = 1'b0;
    rst_n     = 1'b1;
    @(negedge clk);

    run_frame(0, 0);   // flat
    run_frame(1, 0);   // vertical step
    run_frame(2, 0);   // horizontal ramp
    run_frame(3, 0);   // random texture
    run_frame(1, 50);  // step with clken gaps
    run_frame(3, 30);  // random with gaps

    // Mid-frame reset: outputs clear at once, in-flight pixels are dropped
    fill(3);
    drive_frame(0, H/2);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs();
    expq.delete();
    repeat (2) begin
      @(negedge clk);
      bus.clken = ~bus.clken;
      chk_reset_outputs();
    end
    @(negedge clk);
    bus.clken = 1'b0;
    rst_n     = 1'b1;
    @(negedge clk);
    run_frame(1, 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
